// File: rtl/bus_cycle_controller.sv
// Purpose: sequence each 68000 bus cycle, insert per-region waits, then drive DTACK or BERR.
// Latency: DTACK low after start edge + region WAIT + 1 (DRAM: the edge DramDtack_L is seen).
// Backpressure: acknowledge or error is held until the CPU negates AS_L; AS_L high mid-cycle aborts it.
module bus_cycle_controller #(
    parameter int ROM_WAIT = 1,
    parameter int RAM_WAIT = 0,
    parameter int IO_WAIT  = 2,
    parameter int TIMEOUT  = 255
) (
    input  logic Clk,
    input  logic Reset_L,
    input  logic AS_L,
    input  logic UDS_L,
    input  logic LDS_L,
    input  logic OnChipRomSelect_H,
    input  logic OnChipRamSelect_H,
    input  logic IOSelect_H,
    input  logic DramSelect_H,
    input  logic DramDtack_L,
    output logic DtackOut_L,
    output logic BErr_L,
    output logic CycleActive_H
);

    typedef enum logic [2:0] {
        IDLE,
        COUNT,
        DRAMWAIT,
        ACK,
        BERR
    } state_t;

    localparam logic [7:0] ROM_W8  = 8'(ROM_WAIT);
    localparam logic [7:0] RAM_W8  = 8'(RAM_WAIT);
    localparam logic [7:0] IO_W8   = 8'(IO_WAIT);
    // The timeout compares against the pre-increment count, so the last allowed value is TIMEOUT-1.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] wait_cnt;
    logic [7:0] tmo_cnt;
    logic       unmapped;
    logic       cycle_start;

    // A cycle begins when the address strobe and at least one data strobe are asserted.
    assign cycle_start = !AS_L && (!UDS_L || !LDS_L);

    // Bus cycle state machine; every output is a register updated alongside the state.
    always_ff @(posedge Clk or negedge Reset_L) begin
        if (!Reset_L) begin
            state         <= IDLE;
            wait_cnt      <= 8'd0;
            tmo_cnt       <= 8'd0;
            unmapped      <= 1'b0;
            DtackOut_L    <= 1'b1;
            BErr_L        <= 1'b1;
            CycleActive_H <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    DtackOut_L <= 1'b1;
                    BErr_L     <= 1'b1;
                    if (cycle_start) begin
                        tmo_cnt       <= 8'd0;
                        CycleActive_H <= 1'b1;
                        unmapped      <= 1'b0;
                        // Selects are captured here only; later changes are ignored.
                        if (OnChipRomSelect_H) begin
                            wait_cnt <= ROM_W8;
                            state    <= COUNT;
                        end else if (OnChipRamSelect_H) begin
                            wait_cnt <= RAM_W8;
                            state    <= COUNT;
                        end else if (IOSelect_H) begin
                            wait_cnt <= IO_W8;
                            state    <= COUNT;
                        end else if (DramSelect_H) begin
                            wait_cnt <= 8'd0;
                            state    <= DRAMWAIT;
                        end else begin
                            // Unmapped: park in COUNT until the timeout converts it to a bus error.
                            wait_cnt <= 8'd0;
                            unmapped <= 1'b1;
                            state    <= COUNT;
                        end
                    end else begin
                        CycleActive_H <= 1'b0;
                    end
                end

                COUNT: begin
                    if (AS_L) begin
                        state         <= IDLE;
                        wait_cnt      <= 8'd0;
                        tmo_cnt       <= 8'd0;
                        unmapped      <= 1'b0;
                        CycleActive_H <= 1'b0;
                    end else begin
                        if (tmo_cnt != 8'hFF) begin
                            tmo_cnt <= tmo_cnt + 8'd1;
                        end
                        if (unmapped) begin
                            if (tmo_cnt == TO_LAST) begin
                                state  <= BERR;
                                BErr_L <= 1'b0;
                            end
                        end else if (wait_cnt != 8'd0) begin
                            wait_cnt <= wait_cnt - 8'd1;
                        end else begin
                            state      <= ACK;
                            DtackOut_L <= 1'b0;
                        end
                    end
                end

                DRAMWAIT: begin
                    if (AS_L) begin
                        state         <= IDLE;
                        wait_cnt      <= 8'd0;
                        tmo_cnt       <= 8'd0;
                        CycleActive_H <= 1'b0;
                    end else if (!DramDtack_L) begin
                        // A DRAM acknowledge on the expiry edge still wins over the bus error.
                        state      <= ACK;
                        DtackOut_L <= 1'b0;
                    end else if (tmo_cnt == TO_LAST) begin
                        state  <= BERR;
                        BErr_L <= 1'b0;
                    end else if (tmo_cnt != 8'hFF) begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end

                ACK: begin
                    if (AS_L) begin
                        state         <= IDLE;
                        DtackOut_L    <= 1'b1;
                        CycleActive_H <= 1'b0;
                        wait_cnt      <= 8'd0;
                        tmo_cnt       <= 8'd0;
                        unmapped      <= 1'b0;
                    end
                end

                BERR: begin
                    if (AS_L) begin
                        state         <= IDLE;
                        BErr_L        <= 1'b1;
                        CycleActive_H <= 1'b0;
                        wait_cnt      <= 8'd0;
                        tmo_cnt       <= 8'd0;
                        unmapped      <= 1'b0;
                    end
                end

                default: begin
                    state         <= IDLE;
                    DtackOut_L    <= 1'b1;
                    BErr_L        <= 1'b1;
                    CycleActive_H <= 1'b0;
                end
            endcase
        end
    end

endmodule
